// File: rtl/bht_pkg.sv
// ---------------------------------------------------------------------------
// bht_pkg
// Shared types and helpers for the branch history table scheduler.
//   ctr_t      : 2-bit saturating branch counter (MSB = predicted taken)
//   CTR_MIN/MAX: saturation limits of the counter
//   state_t    : table controller state (clearing the table, or serving ports)
//   sat_update : next counter value for a resolved branch outcome
// ---------------------------------------------------------------------------
package bht_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_MIN = 2'b00;
    localparam ctr_t CTR_MAX = 2'b11;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    function automatic ctr_t sat_update(ctr_t c, logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == CTR_MAX) ? CTR_MAX : ctr_t'(c + 2'd1);
        end else begin
            r = (c == CTR_MIN) ? CTR_MIN : ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// ---------------------------------------------------------------------------
// bht_upd_fifo
// Small synchronous FIFO holding resolved-branch updates until the table
// has a free slot. Storage is not reset; only pointers and count are.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   push, push_data  : enqueue request and payload (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   pop_data         : current head entry (valid when !empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module bht_upd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/bht_scheduler.sv
// ---------------------------------------------------------------------------
// bht_scheduler
// Single-ported table of 2-bit saturating branch counters shared between a
// fetch-side predict port and an execute-side update port. Updates are
// queued in a FIFO; predicts win the table slot unless the FIFO is full.
// After reset the table is cleared to INIT_VAL, one entry per cycle.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/req_pc/req_ready    : predict request handshake
//   pred_valid/pred_taken         : prediction, one cycle after acceptance
//   upd_valid/upd_pc/upd_taken    : resolved branch offered for update
//   upd_ready                     : update enqueued when valid && ready
//   init_done                     : table clear has finished
// ---------------------------------------------------------------------------
module bht_scheduler
    import bht_pkg::*;
#(
    parameter int   PC_W      = 32,
    parameter int   IDX_BITS  = 6,
    parameter int   UPD_DEPTH = 4,
    parameter ctr_t INIT_VAL  = 2'b00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [PC_W-1:0] req_pc,
    output logic            req_ready,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready,
    output logic            init_done
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int CNT_W   = $clog2(UPD_DEPTH) + 1;
    localparam int FW      = IDX_BITS + 1;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
    ctr_t                tbl [ENTRIES];

    logic [IDX_BITS-1:0] req_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [IDX_BITS-1:0] head_idx;
    logic                head_taken;
    logic [FW-1:0]       fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic                port_ready;
    logic                pred_fire;
    logic                upd_slot;
    logic                upd_push;
    logic                tbl_we;
    logic [IDX_BITS-1:0] tbl_widx;
    ctr_t                tbl_wval;

    // Only the word-index bits of the PCs select an entry.
    logic                unused_pc_bits;

    assign req_idx = req_pc[IDX_BITS+1:2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_BITS+2], req_pc[1:0],
                              upd_pc[PC_W-1:IDX_BITS+2], upd_pc[1:0]};

    assign {head_idx, head_taken} = fifo_head;
    assign upd_push = upd_valid && port_ready;

    bht_upd_fifo #(
        .WIDTH (FW),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_push),
        .push_data ({upd_idx, upd_taken}),
        .pop       (upd_slot),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Controller: table clear sequencing and single-slot arbitration.
    // Readiness depends only on registered state, never on the valids.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        port_ready = 1'b0;
        pred_fire  = 1'b0;
        upd_slot   = 1'b0;
        tbl_we     = 1'b0;
        tbl_widx   = init_ptr_q;
        tbl_wval   = INIT_VAL;
        case (state_q)
            S_INIT: begin
                tbl_we     = 1'b1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == IDX_BITS'(ENTRIES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                port_ready = (fifo_count != CNT_W'(UPD_DEPTH));
                if (fifo_full) begin
                    upd_slot = 1'b1;
                end else if (req_valid) begin
                    pred_fire = 1'b1;
                end else if (!fifo_empty) begin
                    upd_slot = 1'b1;
                end
                // Read-modify-write of the head entry completes in one cycle.
                if (upd_slot) begin
                    tbl_we   = 1'b1;
                    tbl_widx = head_idx;
                    tbl_wval = sat_update(tbl[head_idx], head_taken);
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Stage boundary: table read -> registered prediction (1-cycle latency).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            pred_valid <= pred_fire;
            if (pred_fire) pred_taken <= tbl[req_idx][1];
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) tbl[tbl_widx] <= tbl_wval;
    end

    assign req_ready = port_ready;
    assign upd_ready = port_ready;
    assign init_done = (state_q == S_RUN);

endmodule

// File: doc/bht_scheduler.md
Name: bht_scheduler

Overview:
- Schedules a table of 2-bit saturating branch counters, shared between the fetch-stage predict port and the execute-stage resolve/update port.
- The table is single-access: one operation per cycle, either a predict read or an update read-modify-write.
- Updates are buffered in a small FIFO. Predicts get priority until the FIFO fills.
- An init state machine clears the table after reset, then the block serves both ports.

Parameters:
- PC_W, 32: width of the program-counter inputs.
- IDX_BITS, 6: log2 of the table entries (64 entries). Index is pc[IDX_BITS+1:2].
- UPD_DEPTH, 4: depth of the update FIFO; must be a power of 2 and at least 2.
- INIT_VAL, 2'b00: counter value written to every entry during init (strongly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch requests a prediction.
- req_pc  in  PC_W  PC of the branch to predict.
- req_ready  out  1  predict is accepted this cycle when req_valid and req_ready are both 1.
- pred_valid  out  1  one-cycle pulse: a prediction is presented.
- pred_taken  out  1  predicted direction (MSB of the counter).
- upd_valid  in  1  a resolved branch is offered for update.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome of the resolved branch.
- upd_ready  out  1  the update is enqueued when upd_valid and upd_ready are both 1.
- init_done  out  1  high once table init is complete.

Behaviour:
- Reset (async, active-high) state: INIT state, init pointer 0, FIFO empty, req_ready=0, upd_ready=0, pred_valid=0, pred_taken=0, init_done=0. The table array itself is not reset.
- FSM INIT:
  - Each cycle write INIT_VAL to table[ptr], then ptr+1.
  - After writing entry 2^IDX_BITS-1, go to RUN; init_done=1 from the next cycle.
  - Init therefore takes exactly 2^IDX_BITS cycles.
  - Both ports report not-ready throughout INIT.
- FSM RUN: stays in RUN until reset.
- Readiness in RUN:
  - upd_ready = (count != UPD_DEPTH).
  - req_ready = (count != UPD_DEPTH).
  - Both are combinational from registered state only; no dependence on the valids.
- Slot arbitration in RUN, evaluated each cycle:
  - FIFO full: update slot; predict stalls.
  - Otherwise, req_valid=1: predict slot.
  - Otherwise, FIFO not empty: update slot.
  - Otherwise: idle.
- Predict slot:
  - Read table[idx(req_pc)].
  - Next cycle, pred_valid=1 and pred_taken = counter[1].
  - Latency is 1 cycle, fully pipelined: one predict per cycle back-to-back.
  - pred_valid=0 in any cycle without an accepted predict in the previous cycle.
- Update slot:
  - Pop the FIFO head {idx, taken} and write back the saturating result in the same cycle.
  - taken=1: 11 stays 11, else +1.
  - taken=0: 00 stays 00, else -1.
  - The new value is visible to a predict from the next cycle.
- No forwarding: a predict to an index with pending FIFO updates returns the stale table value. This is intended.
- FIFO:
  - Stores {idx, taken} at enqueue.
  - Enqueue and pop in the same cycle leave count unchanged.
  - An enqueue into an empty FIFO cannot be popped in that same cycle; there is no bypass.
  - Pointers wrap modulo UPD_DEPTH.
  - count is 0..UPD_DEPTH, width clog2(UPD_DEPTH)+1.
- Starvation bounds:
  - Updates are never dropped.
  - A continuous predict stream stalls for exactly one cycle each time the FIFO reaches full.
- Reset mid-operation: the FIFO contents and any in-flight pred_valid are discarded, and init restarts from entry 0.

Decomposition:
- Package bht_pkg:
  - typedef ctr_t (2 bits) and constants CTR_MIN=2'b00, CTR_MAX=2'b11.
  - Function sat_update(ctr_t c, logic taken) returns ctr_t.
  - Enum state_t {S_INIT, S_RUN}.
- Sub-module bht_upd_fifo:
  - Parameterised width/depth, synchronous FIFO with async reset.
  - Interface: push/pop/full/empty/count.
  - Instantiated once.
- Table, FSM and arbiter stay in the top level.

Test Plan:
- Init sequence: deassert reset, drive req_valid=1 -> req_ready=0 for exactly 64 cycles, then init_done=1 and req_ready=1; the first predict to any PC gives pred_taken=0.
- Saturation: 3 updates taken=1 to PC 0x40 (idx 16), drain, then predict 0x40 -> pred_taken=1. Counter stays 11 after a 4th taken update. Then 2 not-taken updates -> pred_taken=0, and the counter stays at 00 after further not-taken updates.
- Back-to-back predicts to 0x0, 0x4, 0x8 on consecutive cycles -> pred_valid high for 3 consecutive cycles, each 1 cycle after acceptance.
- Update priority: hold req_valid=1 and push 4 updates -> FIFO full, req_ready drops for exactly 1 cycle while one update drains. No update is lost: final table values match the reference model.
- Aliasing and stale read: update 0x100 taken (idx 0) and predict 0x0 in the same cycle -> predict wins and returns the old value. The update is applied later when the port idles, after which the prediction for 0x0 reflects it.
- Async reset asserted mid-stream with the FIFO at 2 entries -> pred_valid, req_ready and upd_ready drop immediately. After release, re-init takes 64 cycles, and the queued updates have no effect on the table.
